// File: rtl/pll_lock_sequencer.sv
// PLL power-up/lock sequencer: reset hold, lock wait with bounded retries, stability qualification, run.
// Optional macro PLL_SEQ_AUTORELOCK_EN: loss of lock in RUN re-sequences instead of latching FAIL.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    // state     | meaning
    // PLL_RST   | PLL held in reset for RST_CYCLES
    // WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
    // STABLE    | lock must persist STABLE_CYCLES consecutive cycles
    // RUN       | downstream logic released
    // FAIL      | retries exhausted or lock lost; waits for restart
    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    logic             sync1_q;
    logic             locked_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             pll_rst_q, sys_rst_n_q, ready_q, fail_q;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                        state_d = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                // a deassertion wins even on the terminal count
                if (!locked_s_q)            state_d = S_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s_q) begin
`ifdef PLL_SEQ_AUTORELOCK_EN
                    state_d = S_PLL_RST;
                    retry_d = '0;
`else
                    state_d = S_FAIL;
`endif
                end
            end
            S_FAIL: begin
                cnt_d = '0;
                if (restart) begin
                    state_d = S_PLL_RST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                retry_d = '0;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        if ((state_d == S_RUN) && (state_q != S_RUN)) retry_d = '0;
    end

    // outputs decode the next state so they move on the transition edge
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
            sys_rst_n_q <= (state_d == S_RUN);
            ready_q     <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Table-driven bench for pll_lock_sequencer (RST=4, TIMEOUT=20, STABLE=8, RETRIES=2).
// Each record drives inputs for N cycles (N=0: check right after driving, for async reset).
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    pll_lock_sequencer #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt), .state(state)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string      name;
        bit         rst;
        bit         locked;
        bit         restart;
        int         cycles;
        logic [2:0] st;
        logic [3:0] retry;
        logic [3:0] outs;   // {pll_rst, sys_rst_n, ready, fail}
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] val;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic void add(string nm, bit r, bit lk, bit rs, int cyc,
                                logic [2:0] st, logic [3:0] rt, logic [3:0] o);
        vec_t v;
        v.name = nm; v.rst = r; v.locked = lk; v.restart = rs; v.cycles = cyc;
        v.st = st; v.retry = rt; v.outs = o;
        vecs.push_back(v);
    endfunction

    task automatic compare_head();
        exp_t e;
        logic [10:0] act;
        act = {state, retry_cnt, pll_rst, sys_rst_n, ready, fail};
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry, got %b", act);
        end else begin
            e = sb.pop_front();
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got state=%0d retry=%0d {pr,srn,rdy,fl}=%b, want state=%0d retry=%0d {pr,srn,rdy,fl}=%b",
                          e.name, act[10:8], act[7:4], act[3:0], e.val[10:8], e.val[7:4], e.val[3:0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passes want %0d", n_pass, vecs.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // nominal lock at cycle 10
        add("reset_values",   0, 0, 0, 0, 0, 0, 4'b1000);
        add("rst_hold_0_2",   1, 0, 0, 3, 0, 0, 4'b1000);
        add("enter_wait",     1, 0, 0, 1, 1, 0, 4'b0000);
        add("wait_no_lock",   1, 0, 0, 6, 1, 0, 4'b0000);
        add("lock_sync_lat",  1, 1, 0, 2, 1, 0, 4'b0000);
        add("enter_stable",   1, 1, 0, 1, 2, 0, 4'b0000);
        add("stable_count",   1, 1, 0, 7, 2, 0, 4'b0000);
        add("enter_run",      1, 1, 0, 1, 3, 0, 4'b0110);
        add("run_restart_ign",1, 1, 1, 5, 3, 0, 4'b0110);
        // async reset out of RUN, then a one-cycle glitch in STABLE
        add("arst_from_run",  0, 1, 0, 0, 0, 0, 4'b1000);
        add("rel_full_hold",  1, 1, 0, 4, 1, 0, 4'b0000);
        add("stable_in",      1, 1, 0, 1, 2, 0, 4'b0000);
        add("stable_4",       1, 1, 0, 4, 2, 0, 4'b0000);
        add("glitch_low",     1, 0, 0, 1, 2, 0, 4'b0000);
        add("glitch_high",    1, 1, 0, 1, 2, 0, 4'b0000);
        add("glitch_to_wait", 1, 1, 0, 1, 1, 0, 4'b0000);
        add("re_stable",      1, 1, 0, 1, 2, 0, 4'b0000);
        add("re_stable_7",    1, 1, 0, 7, 2, 0, 4'b0000);
        add("re_run",         1, 1, 0, 1, 3, 0, 4'b0110);
        add("run_drop_sync",  1, 0, 0, 2, 3, 0, 4'b0110);
`ifdef PLL_SEQ_AUTORELOCK_EN
        add("run_drop_relock",1, 0, 0, 1, 0, 0, 4'b1000);
`else
        add("run_drop_fail",  1, 0, 0, 1, 4, 0, 4'b1001);
`endif
        // no lock: three attempts then FAIL, restart, then async reset mid-WAIT
        add("arst_2",         0, 0, 0, 0, 0, 0, 4'b1000);
        add("a1_to_wait",     1, 0, 0, 4, 1, 0, 4'b0000);
        add("a1_wait_restart",1, 0, 1, 19, 1, 0, 4'b0000);
        add("a1_timeout",     1, 0, 0, 1, 0, 1, 4'b1000);
        add("a2_rst_hold",    1, 0, 0, 3, 0, 1, 4'b1000);
        add("a2_to_wait",     1, 0, 0, 1, 1, 1, 4'b0000);
        add("a2_wait",        1, 0, 0, 19, 1, 1, 4'b0000);
        add("a2_timeout",     1, 0, 0, 1, 0, 2, 4'b1000);
        add("a3_to_wait",     1, 0, 0, 4, 1, 2, 4'b0000);
        add("a3_wait",        1, 0, 0, 19, 1, 2, 4'b0000);
        add("enter_fail",     1, 0, 0, 1, 4, 2, 4'b1001);
        add("fail_ignores_lk",1, 1, 0, 30, 4, 2, 4'b1001);
        add("restart_pulse",  1, 0, 1, 1, 0, 0, 4'b1000);
        add("rs_rst_hold",    1, 0, 0, 3, 0, 0, 4'b1000);
        add("rs_to_wait",     1, 0, 0, 1, 1, 0, 4'b0000);
        add("rs_wait",        1, 0, 0, 19, 1, 0, 4'b0000);
        add("rs_timeout",     1, 0, 0, 1, 0, 1, 4'b1000);
        add("rs_wait_again",  1, 0, 0, 4, 1, 1, 4'b0000);
        add("mid_wait_r1",    1, 0, 0, 5, 1, 1, 4'b0000);
        add("arst_mid_wait",  0, 0, 0, 0, 0, 0, 4'b1000);
        add("rel_restart_ign",1, 0, 1, 3, 0, 0, 4'b1000);
        add("full_hold_end",  1, 0, 0, 1, 1, 0, 4'b0000);

        @(negedge refclk);
        foreach (vecs[i]) begin
            exp_t e;
            rst        = vecs[i].rst;
            pll_locked = vecs[i].locked;
            restart    = vecs[i].restart;
            e.name = vecs[i].name;
            e.val  = {vecs[i].st, vecs[i].retry, vecs[i].outs};
            sb.push_back(e);
            if (vecs[i].cycles == 0) begin
                #1;
            end else begin
                repeat (vecs[i].cycles) @(posedge refclk);
                @(negedge refclk);
            end
            compare_head();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of refclk cycles the PLL reset is held per attempt (>=1).
REQ-002 Parameter LOCK_TIMEOUT, default 1000: number of cycles in WAIT_LOCK before an attempt is declared failed (>=2).
REQ-003 Parameter STABLE_CYCLES, default 64: number of consecutive synchronized-locked cycles required before RUN (>=1).
REQ-004 Parameter MAX_RETRIES, default 3: number of re-attempts after the first timeout before FAIL (0..15).
REQ-005 refclk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset: assertion takes effect immediately; release is synchronous to refclk.
REQ-007 pll_locked  input  1  PLL lock indicator, asynchronous to refclk.
REQ-008 restart  input  1  synchronous single-cycle request to leave FAIL.
REQ-009 pll_rst  output  1  active-high reset to the PLL.
REQ-010 sys_rst_n  output  1  active-low reset to the downstream logic.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fail  output  1  high only in FAIL.
REQ-013 retry_cnt  output  4  number of timeouts in the current sequence.
REQ-014 state  output  3  encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s (2-cycle input latency).
REQ-016 All outputs SHALL be registered and SHALL change on the same edge as the state transition that selects them.
REQ-017 Output decode: pll_rst=1 in PLL_RST and FAIL, otherwise 0; sys_rst_n=1 only in RUN; ready=(state==RUN); fail=(state==FAIL).
REQ-018 A single cycle counter SHALL clear on every state transition.
REQ-019 PLL_RST: when the counter reaches RST_CYCLES-1 -> WAIT_LOCK.
REQ-020 WAIT_LOCK:
- locked_s=1 -> STABLE.
- Otherwise, at counter==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES -> FAIL; else retry_cnt+1 and -> PLL_RST.
REQ-021 STABLE:
- locked_s=0 -> WAIT_LOCK, with a fresh timeout window.
- Counter reaching STABLE_CYCLES-1 with locked_s=1 -> RUN.
- Deassertion SHALL take priority on the same cycle.
REQ-022 RUN: retry_cnt SHALL clear on entry. locked_s=0 -> loss-of-lock handling per REQ-028/029.
REQ-023 FAIL: restart=1 -> PLL_RST with retry_cnt=0. Otherwise FAIL is held indefinitely; pll_locked is ignored.
REQ-024 restart SHALL be ignored in every state other than FAIL.
REQ-025 retry_cnt SHALL saturate at 15 and never wrap.

Reset
REQ-026 On rst low:
- state=PLL_RST, counter=0, synchronizer flops=0, retry_cnt=0.
- pll_rst=1, sys_rst_n=0, ready=0, fail=0.
- This applies from any state, including mid-count and RUN.
REQ-027 After rst is released, the full sequence SHALL restart from PLL_RST with a full RST_CYCLES hold.

Configuration
REQ-028 With macro PLL_SEQ_AUTORELOCK_EN defined, loss of lock in RUN -> PLL_RST with retry_cnt=0; sys_rst_n drops on that same edge.
REQ-029 Without PLL_SEQ_AUTORELOCK_EN, loss of lock in RUN -> FAIL; sys_rst_n drops on that same edge and recovery requires restart.

Verification
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-030 Lock at cycle 10 after rst release, held high -> pll_rst=1 for cycles 0-3; STABLE entered 2 cycles after lock is seen; ready=sys_rst_n=1 eight cycles later; retry_cnt=0.
REQ-031 pll_locked held low -> three PLL_RST/WAIT_LOCK attempts with retry_cnt 0->1->2, then fail=1, pll_rst=1, state=4. A restart pulse -> state=0, retry_cnt=0.
REQ-032 In STABLE, drop pll_locked for 1 cycle after 5 stable cycles -> return to WAIT_LOCK; RUN only after 8 further consecutive locked cycles.
REQ-033 In RUN, drop pll_locked:
- With PLL_SEQ_AUTORELOCK_EN -> sys_rst_n=0 and state=0 three cycles after the drop.
- Without it -> state=4 and fail=1.
REQ-034 Assert rst mid-WAIT_LOCK with retry_cnt=1 -> outputs return to reset values asynchronously; restart pulses outside FAIL have no effect.
